// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that drives an external 8-bit ALU: fetches an optional memory operand,
// executes for one cycle, then writes back to the accumulator or, for RMW shifts, to memory.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_src_mem,
  input  logic        req_rmw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_imm,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_mode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry_out,
  input  logic        alu_overflow,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  acc,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] OpAdc = 4'd0;
  localparam logic [3:0] OpSbc = 4'd4;
  localparam logic [3:0] OpAsl = 4'd5;
  localparam logic [3:0] OpRor = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        rmw_q, rmw_d;
  logic [7:0]  operand_q, operand_d;
  logic [7:0]  acc_q, acc_d;
  logic        n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d, err_q, err_d;

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OpAsl) && (op <= OpRor);
  endfunction

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rmw_d        = rmw_q;
    operand_d    = operand_q;
    acc_d        = acc_q;
    n_d          = n_q;
    v_d          = v_q;
    z_d          = z_q;
    c_d          = c_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    req_ready    = (state_q == StIdle);
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_mode     = 5'd0;
    alu_carry_in = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op > OpCmp) begin
            err_d = 1'b1;
          end else begin
            op_d       = req_op;
            rmw_d      = req_rmw & is_shift(req_op);
            mem_addr_d = req_addr;
            operand_d  = req_imm;
            if (req_src_mem || req_rmw) begin
              mem_rd_d = 1'b1;
              state_d  = StRead;
            end else begin
              state_d  = StExec;
            end
          end
        end
      end
      StRead: begin
        if (mem_ack) begin
          operand_d = mem_rdata;
          mem_rd_d  = 1'b0;
          state_d   = StExec;
        end
      end
      StExec: begin
        alu_mode     = (op_q == OpCmp) ? {1'b0, OpSbc} : {1'b0, op_q};
        alu_carry_in = c_q;
        if (is_shift(op_q)) begin
          alu_a = rmw_q ? operand_q : acc_q;
        end else begin
          alu_a = acc_q;
          alu_b = operand_q;
        end
        n_d = alu_out[7];
        z_d = (alu_out == 8'h00);
        // Logical ops preserve C; only ADC/SBC touch V (CMP leaves it alone).
        if (op_q == OpAdc || op_q == OpSbc || op_q == OpCmp || is_shift(op_q)) begin
          c_d = alu_carry_out;
        end
        if (op_q == OpAdc || op_q == OpSbc) begin
          v_d = alu_overflow;
        end
        if (rmw_q) begin
          mem_wr_d    = 1'b1;
          mem_wdata_d = alu_out;
          state_d     = StWrite;
        end else begin
          if (op_q != OpCmp) begin
            acc_d = alu_out;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 4'd0;
      rmw_q       <= 1'b0;
      operand_q   <= 8'h00;
      acc_q       <= 8'h00;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rmw_q       <= rmw_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      v_q         <= v_d;
      z_q         <= z_d;
      c_q         <= c_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign acc       = acc_q;
  assign flags     = {n_q, v_q, z_q, c_q};
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a bus responder of programmable wait.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic        req_src_mem = 1'b0;
  logic        req_rmw = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_imm = 8'h00;
  logic [7:0]  alu_a, alu_b;
  logic [4:0]  alu_mode;
  logic        alu_carry_in;
  logic [7:0]  alu_out;
  logic        alu_carry_out, alu_overflow;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  acc;
  logic [3:0]  flags;
  logic        done, err;

  int tests = 0;
  int fails = 0;

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_src_mem  (req_src_mem),
    .req_rmw      (req_rmw),
    .req_addr     (req_addr),
    .req_imm      (req_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_carry_out(alu_carry_out),
    .alu_overflow (alu_overflow),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .acc          (acc),
    .flags        (flags),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Behavioural 6502-style ALU.
  logic [8:0] sum;
  logic [7:0] nb;
  always_comb begin
    sum           = 9'd0;
    nb            = ~alu_b;
    alu_out       = 8'h00;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_mode)
      5'd0: begin
        sum           = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
        alu_out       = sum[7:0];
        alu_carry_out = sum[8];
        alu_overflow  = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      5'd1: alu_out = alu_a & alu_b;
      5'd2: alu_out = alu_a | alu_b;
      5'd3: alu_out = alu_a ^ alu_b;
      5'd4: begin
        sum           = {1'b0, alu_a} + {1'b0, nb} + {8'd0, alu_carry_in};
        alu_out       = sum[7:0];
        alu_carry_out = sum[8];
        alu_overflow  = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      5'd5: begin alu_out = {alu_a[6:0], 1'b0};         alu_carry_out = alu_a[7]; end
      5'd6: begin alu_out = {alu_a[6:0], alu_carry_in}; alu_carry_out = alu_a[7]; end
      5'd7: begin alu_out = {1'b0, alu_a[7:1]};         alu_carry_out = alu_a[0]; end
      5'd8: begin alu_out = {alu_carry_in, alu_a[7:1]}; alu_carry_out = alu_a[0]; end
      default: ;
    endcase
  end

  // Bus responder: acks on the ack_wait-th strobe cycle; force_ack injects a stray ack.
  int          ack_wait = 1;
  bit          force_ack = 1'b0;
  logic [7:0]  rdata_val = 8'h00;
  int          strobe_cnt = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [15:0] rd_addr = 16'h0000;
  logic [15:0] wr_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  bit          both_hi = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_rd || mem_wr) strobe_cnt++;
    else strobe_cnt = 0;
    if (mem_rd && mem_wr) both_hi = 1'b1;
    if (mem_rd) begin rd_cycles++; rd_addr = mem_addr; end
    if (mem_wr) begin wr_cycles++; wr_addr = mem_addr; wr_data = mem_wdata; end
    mem_ack   = force_ack || ((mem_rd || mem_wr) && strobe_cnt >= ack_wait);
    mem_rdata = rdata_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns in the cycle after the handshake edge.
  task automatic issue(input logic [3:0] op, input logic src, input logic rmw,
                       input logic [15:0] addr, input logic [7:0] imm);
    req_valid   = 1'b1;
    req_op      = op;
    req_src_mem = src;
    req_rmw     = rmw;
    req_addr    = addr;
    req_imm     = imm;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, rd0, wr0, n_done;
  logic [7:0] acc0;
  logic [3:0] flags0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_acc", acc, 8'h00);
    check("rst_flags", flags, 4'h0);
    check("rst_strobes", {mem_rd, mem_wr, done, err}, 4'h0);
    check("rst_bus", {mem_addr, mem_wdata}, 24'h0);
    check("rst_alu", {alu_a, alu_b, alu_mode, alu_carry_in}, 22'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);

    // ORA #7F, then ADC #01 -> 0x80 with N and V set.
    issue(4'd2, 1'b0, 1'b0, 16'h0, 8'h7F);
    wait_done(lat);
    check("ora_acc", acc, 8'h7F);
    @(negedge clk);
    issue(4'd0, 1'b0, 1'b0, 16'h0, 8'h01);
    check("adc_alu", {alu_a, alu_b, alu_mode, alu_carry_in}, {8'h7F, 8'h01, 5'd0, 1'b0});
    wait_done(lat);
    check("adc_lat", lat, 2);
    check("adc_acc", acc, 8'h80);
    check("adc_flags", flags, 4'b1100);
    @(negedge clk);
    check("done_pulse", done, 1'b0);

    issue(4'd2, 1'b0, 1'b0, 16'h0, 8'h70);
    wait_done(lat);
    check("ora2_acc", acc, 8'hF0);
    @(negedge clk);

    // AND from memory, ack on the third strobe cycle.
    rd0 = rd_cycles; ack_wait = 3; rdata_val = 8'h0F;
    issue(4'd1, 1'b1, 1'b0, 16'h1234, 8'hAA);
    check("and_rd", mem_rd, 1'b1);
    wait_done(lat);
    check("and_lat", lat, 5);
    check("and_rdcyc", rd_cycles - rd0, 3);
    check("and_addr", rd_addr, 16'h1234);
    check("and_acc", acc, 8'h00);
    check("and_flags", flags, 4'b0110);
    @(negedge clk);

    // RMW ASL at 0x0200 with zero-wait read and write.
    rd0 = rd_cycles; wr0 = wr_cycles; ack_wait = 1; rdata_val = 8'h81;
    issue(4'd5, 1'b1, 1'b1, 16'h0200, 8'h00);
    wait_done(lat);
    check("asl_lat", lat, 4);
    check("asl_rdcyc", rd_cycles - rd0, 1);
    check("asl_wrcyc", wr_cycles - wr0, 1);
    check("asl_waddr", wr_addr, 16'h0200);
    check("asl_wdata", wr_data, 8'h02);
    check("asl_acc", acc, 8'h00);
    check("asl_flags", flags, 4'b0101);
    @(negedge clk);

    issue(4'd2, 1'b0, 1'b0, 16'h0, 8'h10);
    wait_done(lat);
    check("ora3_acc", acc, 8'h10);
    @(negedge clk);

    // CMP #10 runs the ALU in SBC mode and leaves acc alone.
    issue(4'd9, 1'b0, 1'b0, 16'h0, 8'h10);
    check("cmp_alu", {alu_a, alu_b, alu_mode, alu_carry_in}, {8'h10, 8'h10, 5'd4, 1'b1});
    wait_done(lat);
    check("cmp_lat", lat, 2);
    check("cmp_acc", acc, 8'h10);
    check("cmp_flags", flags, 4'b0111);
    check("cmp_ready", req_ready, 1'b1);

    // LSR A issued in the same cycle done is high.
    issue(4'd7, 1'b0, 1'b0, 16'h0, 8'hFF);
    check("lsr_alu", {alu_a, alu_mode}, {8'h10, 5'd7});
    wait_done(lat);
    check("lsr_lat", lat, 2);
    check("lsr_acc", acc, 8'h08);
    check("lsr_flags", flags, 4'b0100);
    @(negedge clk);

    // Illegal op 12 is dropped with a single err pulse.
    rd0 = rd_cycles; wr0 = wr_cycles; acc0 = acc; flags0 = flags;
    issue(4'd12, 1'b1, 1'b0, 16'h4444, 8'h55);
    check("ill_err", err, 1'b1);
    check("ill_ready", req_ready, 1'b1);
    check("ill_rd", mem_rd, 1'b0);
    @(negedge clk);
    check("ill_err_once", err, 1'b0);
    check("ill_nodone", done, 1'b0);
    @(negedge clk);
    check("ill_bus", (rd_cycles - rd0) + (wr_cycles - wr0), 0);
    check("ill_state", {acc, flags}, {acc0, flags0});

    // Reset while READ is waiting, then a late ack.
    ack_wait = 1000;
    issue(4'd0, 1'b1, 1'b0, 16'h0300, 8'h00);
    check("rr_rd", mem_rd, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rr_rd_drop", mem_rd, 1'b0);
    check("rr_ready", req_ready, 1'b1);
    reset = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || mem_rd === 1'b1 || mem_wr === 1'b1) n_done++;
      @(negedge clk);
    end
    check("rr_quiet", n_done, 0);
    check("rr_acc", acc, 8'h00);
    check("rr_flags", flags, 4'h0);
    check("rr_ready2", req_ready, 1'b1);
    check("no_both_strobes", both_hi, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 8-bit `alu` datapath for the CPU core. It accepts one arithmetic/logic/shift request at a time from the decoder, fetches a memory operand when needed, and drives the ALU for one cycle. It then writes the result back to the accumulator or, for read-modify-write shifts, to memory, and updates the N, V, Z and C status flags. It sits between the instruction decoder, the `alu` instance and the CPU data-bus interface.

## Interface
- No parameters. Widths are fixed at 8-bit data and 16-bit address.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: decoder presents a request.
- `req_ready` out 1: sequencer can accept; high only in IDLE.
- `req_op` in 4: 0 ADC, 1 AND, 2 ORA, 3 EOR, 4 SBC, 5 ASL, 6 ROL, 7 LSR, 8 ROR, 9 CMP; 10–15 are illegal.
- `req_src_mem` in 1: 1 = operand comes from memory at `req_addr`; 0 = operand is `req_imm`.
- `req_rmw` in 1: shifts only; 1 = shift the memory operand and write it back; 0 = shift the accumulator.
- `req_addr` in 16: operand and write-back address.
- `req_imm` in 8: immediate operand.
- `alu_a`, `alu_b` out 8: ALU operands.
- `alu_mode` out 5: ALU mode code (same encoding as `req_op`, zero-extended).
- `alu_carry_in` out 1: current C flag.
- `alu_out` in 8, `alu_carry_out` in 1, `alu_overflow` in 1: ALU results.
- `mem_rd` out 1, `mem_wr` out 1, `mem_addr` out 16, `mem_wdata` out 8: bus request; held until acknowledged.
- `mem_ack` in 1, `mem_rdata` in 8: bus acknowledge and read data, valid in the ack cycle.
- `acc` out 8: accumulator.
- `flags` out 4: {N,V,Z,C}.
- `done` out 1: one-cycle pulse when a request retires.
- `err` out 1: one-cycle pulse when an illegal op is dropped.

## Operation
- States: IDLE, READ, EXEC, WRITE.
- IDLE:
  - `req_ready`=1. A handshake (`req_valid`&`req_ready`) latches op, src, rmw, addr and imm.
  - Illegal op: stay in IDLE and pulse `err` next cycle; no state change.
  - Legal op with src_mem=1 or rmw=1: go to READ.
  - Otherwise: go to EXEC with operand = imm.
- READ: `mem_rd`=1 and `mem_addr`=addr. On `mem_ack`, latch `mem_rdata` as the operand and go to EXEC. No timeout.
- EXEC drives the ALU combinationally for one cycle:
  - Two-operand ops and CMP: `alu_a`=acc, `alu_b`=operand.
  - Accumulator shifts: `alu_a`=acc.
  - RMW shifts: `alu_a`=operand.
  - CMP drives `alu_mode`=SBC.
  - `alu_out` is registered as the result at the end of EXEC.
- Flag update at the end of EXEC:
  - N = result[7]; Z = (result==0) for every op.
  - C = `alu_carry_out` for ADC, SBC, CMP and shifts; unchanged for AND/ORA/EOR.
  - V = `alu_overflow` for ADC/SBC only.
- Writeback:
  - Non-RMW op other than CMP: `acc` takes the result at the end of EXEC. CMP leaves `acc` unchanged.
  - Non-RMW: `done` pulses in the cycle after EXEC, and the next state is IDLE.
  - RMW: go to WRITE. `mem_wr`=1, `mem_addr`=addr, `mem_wdata`=result until `mem_ack`; then go to IDLE and pulse `done` the next cycle. `acc` is never written by RMW.
- `mem_rd` and `mem_wr` are never high together. Both are registered outputs.
- A `mem_ack` while neither strobe is high is ignored.
- `req_valid` while not in IDLE is ignored; the request is not queued.

## Timing
- Reset values: state IDLE, `acc`=0x00, `flags`=0, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `done`=`err`=0, `alu_*` outputs 0. `req_ready` goes to 1 the cycle after reset deasserts.
- Reset in any state returns to IDLE on that edge and drops the bus strobes on the same edge. No `done` is produced for the aborted request, and a late `mem_ack` is ignored.
- Latency from handshake to `done`:
  - Immediate: 2 cycles (EXEC, then done).
  - Memory operand: 3 + read-wait cycles.
  - RMW: 4 + read-wait + write-wait cycles.
  - A zero-wait ack (ack in the first strobe cycle) counts as 0 wait.
- After `done`, a new request is accepted in the same cycle `done` is high (IDLE).
- Back-to-back immediate ops therefore issue every 2 cycles.

## Test plan
- Reset, then ADC imm 0x01 with acc=0x7F, C=0: `done` 2 cycles after handshake; acc=0x80, flags N=1, V=1, Z=0, C=0.
- AND from memory with `mem_ack` delayed 3 cycles, `mem_rdata`=0x0F, acc=0xF0: `mem_rd` held exactly 3 cycles with `mem_addr`=req_addr; acc=0x00, Z=1, C unchanged.
- RMW ASL at 0x0200 with rdata 0x81: `mem_wr` with `mem_wdata`=0x02; C=1, Z=0, N=0; acc unchanged; `done` after the write ack.
- CMP imm 0x10 with acc=0x10: acc stays 0x10, Z=1; `alu_mode`=SBC during EXEC.
- Illegal op 12: `err` pulses once, no bus activity, acc and flags unchanged, `req_ready` stays high.
- `reset` asserted in READ with `mem_ack` arriving in the following cycle: IDLE on the reset edge, `mem_rd` drops on that edge, no `done`, acc=0x00.
